// File: rtl/aq_axis_upsizer.sv
// ---------------------------------------------------------------------------
// aq_axis_upsizer
//
// AXI-Stream width up-converter. Packs RATIO consecutive narrow input beats
// into one wide output beat, first beat in the least-significant lane. A
// TLAST beat that arrives before every lane is filled flushes the word early;
// the unused upper lanes are zero and their TKEEP bits are clear. Packets
// never merge across TLAST. The output stage is a single register that
// sustains one input beat per clock while M_AXIS_TREADY stays high.
//
// Parameters:
//   IN_WIDTH   input data width in bits (multiple of 8)
//   RATIO      input beats per output beat (2, 4 or 8)
//   OUT_WIDTH  IN_WIDTH*RATIO, derived; leave at its default
//
// Ports:
//   ACLK           clock shared by both stream sides
//   RST            asynchronous, active-high reset
//   S_AXIS_TVALID  input beat valid
//   S_AXIS_TREADY  input beat accepted when TVALID && TREADY
//   S_AXIS_TDATA   input data (IN_WIDTH bits)
//   S_AXIS_TLAST   last beat of the input packet
//   M_AXIS_TVALID  output beat valid
//   M_AXIS_TREADY  downstream ready
//   M_AXIS_TDATA   packed data, lane i = [i*IN_WIDTH +: IN_WIDTH]
//   M_AXIS_TKEEP   per-lane valid mask (RATIO bits)
//   M_AXIS_TLAST   output beat ends a packet
// ---------------------------------------------------------------------------
module aq_axis_upsizer #(
  parameter int IN_WIDTH  = 32,
  parameter int RATIO     = 2,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 ACLK,
  input  logic                 RST,
  input  logic                 S_AXIS_TVALID,
  output logic                 S_AXIS_TREADY,
  input  logic [IN_WIDTH-1:0]  S_AXIS_TDATA,
  input  logic                 S_AXIS_TLAST,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic [OUT_WIDTH-1:0] M_AXIS_TDATA,
  output logic [RATIO-1:0]     M_AXIS_TKEEP,
  output logic                 M_AXIS_TLAST
);

  localparam int LW    = $clog2(RATIO);
  localparam int ACC_W = IN_WIDTH * (RATIO - 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  // Lane counter and accumulator (lanes 0..RATIO-2 only; the top lane is
  // always supplied directly by the completing beat).
  logic [LW-1:0]        laneQ, laneD;
  logic [ACC_W-1:0]     accDataQ, accDataD;
  logic [RATIO-2:0]     accKeepQ, accKeepD;

  // Output register.
  logic                 mValidQ, mValidD;
  logic [OUT_WIDTH-1:0] mDataQ, mDataD;
  logic [RATIO-1:0]     mKeepQ, mKeepD;
  logic                 mLastQ, mLastD;

  logic                 sReady;
  logic                 accept;
  logic                 complete;
  logic [OUT_WIDTH-1:0] accDataExt;
  logic [RATIO-1:0]     accKeepExt;
  logic [OUT_WIDTH-1:0] packWord;
  logic [RATIO-1:0]     packKeep;

  // The input may advance whenever the output register is empty or is being
  // drained this cycle. Independent of S_AXIS_TVALID/TLAST by design.
  assign sReady   = !mValidQ || M_AXIS_TREADY;
  assign accept   = S_AXIS_TVALID && sReady;
  assign complete = accept && (S_AXIS_TLAST || (laneQ == LAST_LANE));

  // Assemble the wide word for a completing beat: lanes below L come from
  // the accumulator, lane L is the current beat, lanes above L are forced to
  // zero so padding never carries stale accumulator content.
  always_comb begin
    accDataExt = {{IN_WIDTH{1'b0}}, accDataQ};
    accKeepExt = {1'b0, accKeepQ};
    packWord   = '0;
    packKeep   = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (LW'(i) == laneQ) begin
        packWord[i*IN_WIDTH +: IN_WIDTH] = S_AXIS_TDATA;
        packKeep[i]                      = 1'b1;
      end else if (LW'(i) < laneQ) begin
        packWord[i*IN_WIDTH +: IN_WIDTH] = accDataExt[i*IN_WIDTH +: IN_WIDTH];
        packKeep[i]                      = accKeepExt[i];
      end
    end
  end

  // Next-state logic. A drained output word clears TVALID unless a new
  // completing beat reloads the register in the same cycle.
  always_comb begin
    laneD    = laneQ;
    accDataD = accDataQ;
    accKeepD = accKeepQ;
    mValidD  = mValidQ;
    mDataD   = mDataQ;
    mKeepD   = mKeepQ;
    mLastD   = mLastQ;

    if (mValidQ && M_AXIS_TREADY) begin
      mValidD = 1'b0;
    end

    if (complete) begin
      mValidD  = 1'b1;
      mDataD   = packWord;
      mKeepD   = packKeep;
      mLastD   = S_AXIS_TLAST;
      laneD    = '0;
      accDataD = '0;
      accKeepD = '0;
    end else if (accept) begin
      for (int i = 0; i < RATIO - 1; i++) begin
        if (LW'(i) == laneQ) begin
          accDataD[i*IN_WIDTH +: IN_WIDTH] = S_AXIS_TDATA;
          accKeepD[i]                      = 1'b1;
        end
      end
      laneD = laneQ + 1'b1;
    end
  end

  // State registers. Reset discards any partial accumulation and any pending
  // output word.
  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      laneQ    <= '0;
      accDataQ <= '0;
      accKeepQ <= '0;
      mValidQ  <= 1'b0;
      mDataQ   <= '0;
      mKeepQ   <= '0;
      mLastQ   <= 1'b0;
    end else begin
      laneQ    <= laneD;
      accDataQ <= accDataD;
      accKeepQ <= accKeepD;
      mValidQ  <= mValidD;
      mDataQ   <= mDataD;
      mKeepQ   <= mKeepD;
      mLastQ   <= mLastD;
    end
  end

  assign S_AXIS_TREADY = sReady;
  assign M_AXIS_TVALID = mValidQ;
  assign M_AXIS_TDATA  = mDataQ;
  assign M_AXIS_TKEEP  = mKeepQ;
  assign M_AXIS_TLAST  = mLastQ;

endmodule

// File: tb/tb_aq_axis_upsizer.sv
// ---------------------------------------------------------------------------
// tb_aq_axis_upsizer
//
// Scoreboard bench for aq_axis_upsizer. Two instances: RATIO=2 (main) and
// RATIO=4. Packets are described as lists of beats; the reference model
// chops each packet into RATIO-sized chunks and pushes the expected wide
// words into a queue. Independent monitors pop and compare on every output
// transfer.
// ---------------------------------------------------------------------------
module tb_aq_axis_upsizer;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
  } word_t;

  logic ACLK = 1'b0;
  logic RST;

  // RATIO=2 instance signals
  logic        sValid, sReady, sLast;
  logic [31:0] sData;
  logic        mValid, mReady, mLast;
  logic [63:0] mData;
  logic [1:0]  mKeep;

  // RATIO=4 instance signals
  logic         sValid4, sReady4, sLast4;
  logic [31:0]  sData4;
  logic         mValid4, mReady4, mLast4;
  logic [127:0] mData4;
  logic [3:0]   mKeep4;

  word_t       exp2[$];
  word_t       exp4[$];
  logic [31:0] pkt[$];

  int checks = 0;
  int passes = 0;
  int stallCount = 0;
  int cycleCount = 0;
  bit randomReady = 0;

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cycleCount++;

  aq_axis_upsizer #(.IN_WIDTH(32), .RATIO(2)) u_dut2 (
    .ACLK          (ACLK),
    .RST           (RST),
    .S_AXIS_TVALID (sValid),
    .S_AXIS_TREADY (sReady),
    .S_AXIS_TDATA  (sData),
    .S_AXIS_TLAST  (sLast),
    .M_AXIS_TVALID (mValid),
    .M_AXIS_TREADY (mReady),
    .M_AXIS_TDATA  (mData),
    .M_AXIS_TKEEP  (mKeep),
    .M_AXIS_TLAST  (mLast)
  );

  aq_axis_upsizer #(.IN_WIDTH(32), .RATIO(4)) u_dut4 (
    .ACLK          (ACLK),
    .RST           (RST),
    .S_AXIS_TVALID (sValid4),
    .S_AXIS_TREADY (sReady4),
    .S_AXIS_TDATA  (sData4),
    .S_AXIS_TLAST  (sLast4),
    .M_AXIS_TVALID (mValid4),
    .M_AXIS_TREADY (mReady4),
    .M_AXIS_TDATA  (mData4),
    .M_AXIS_TKEEP  (mKeep4),
    .M_AXIS_TLAST  (mLast4)
  );

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] required);
    checks++;
    if (actual === required) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Reference model: a packet of N beats becomes ceil(N/ratio) words; each
  // word holds up to ratio consecutive beats, lowest beat in lane 0, unused
  // lanes zero, keep = one bit per filled lane, last only on the final chunk.
  task automatic modelPacket(input int ratio);
    for (int base = 0; base < pkt.size(); base += ratio) begin
      word_t w;
      int    n;
      w = '0;
      n = (pkt.size() - base < ratio) ? (pkt.size() - base) : ratio;
      for (int j = 0; j < n; j++) begin
        w.data[j*32 +: 32] = pkt[base + j];
      end
      w.keep = 4'((1 << n) - 1);
      w.last = (base + n == pkt.size());
      if (ratio == 2) exp2.push_back(w);
      else            exp4.push_back(w);
    end
  endtask

  // Present one beat to the RATIO=2 instance and hold it until accepted.
  // A completing beat must show up on the output one cycle later.
  task automatic driveBeat(input logic [31:0] data, input logic last,
                           input bit completing);
    int   waitCycles;
    logic took;
    waitCycles = 0;
    took       = 1'b0;
    sValid = 1'b1;
    sData  = data;
    sLast  = last;
    while (!took) begin
      @(negedge ACLK);
      took = sReady;
      @(posedge ACLK);
      #1;
      waitCycles++;
      if (!took && waitCycles > 2000) begin
        checkOutput("beat accept timeout", 128'(waitCycles), 128'(0));
        break;
      end
    end
    if (waitCycles > 1) stallCount++;
    sValid = 1'b0;
    if (took && completing) begin
      checkOutput("valid one cycle after completing beat", 128'(mValid), 128'(1));
    end
  endtask

  // Drive the packet held in pkt through the RATIO=2 instance, with random
  // idle gaps of up to maxGap cycles between beats.
  task automatic applyStimulus(input int maxGap);
    modelPacket(2);
    for (int k = 0; k < pkt.size(); k++) begin
      driveBeat(pkt[k], k == pkt.size() - 1,
                (k % 2 == 1) || (k == pkt.size() - 1));
      if (maxGap > 0) begin
        repeat ($urandom_range(0, maxGap)) begin
          @(posedge ACLK);
          #1;
        end
      end
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((exp2.size() != 0 || exp4.size() != 0) && n < 2000) begin
      @(posedge ACLK);
      n++;
    end
    #1;
    checkOutput("scoreboard drained", 128'(exp2.size() + exp4.size()), 128'(0));
  endtask

  // Random downstream backpressure, only when enabled.
  always @(posedge ACLK) begin
    #1;
    if (randomReady) mReady = ($urandom_range(0, 3) != 0);
  end

  // Monitor for the RATIO=2 instance: every output transfer pops one word.
  always @(negedge ACLK) begin : mon2
    word_t e;
    if (!RST && mValid && mReady) begin
      if (exp2.size() == 0) begin
        checkOutput("dut2 unexpected word", 128'(mData), 128'(0));
        if (mData === 64'd0) begin
          checks++;
          $display("[TB] FAIL dut2 unexpected word: got valid, expected none");
        end
      end else begin
        e = exp2.pop_front();
        checkOutput("dut2 TDATA", 128'(mData), e.data);
        checkOutput("dut2 TKEEP", 128'(mKeep), 128'(e.keep));
        checkOutput("dut2 TLAST", 128'(mLast), 128'(e.last));
      end
    end
  end

  // Monitor for the RATIO=4 instance.
  always @(negedge ACLK) begin : mon4
    word_t e;
    if (!RST && mValid4 && mReady4) begin
      if (exp4.size() == 0) begin
        checks++;
        $display("[TB] FAIL dut4 unexpected word: got 0x%0h, expected none", mData4);
      end else begin
        e = exp4.pop_front();
        checkOutput("dut4 TDATA", mData4, e.data);
        checkOutput("dut4 TKEEP", 128'(mKeep4), 128'(e.keep));
        checkOutput("dut4 TLAST", 128'(mLast4), 128'(e.last));
      end
    end
  end

  initial begin
    logic [63:0] holdData;
    logic [1:0]  holdKeep;
    logic        holdLast;
    int          startCycle;

    RST     = 1'b1;
    sValid  = 1'b0;
    sData   = '0;
    sLast   = 1'b0;
    mReady  = 1'b1;
    sValid4 = 1'b0;
    sData4  = '0;
    sLast4  = 1'b0;
    mReady4 = 1'b1;

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset TVALID", 128'(mValid), 128'(0));
    checkOutput("reset TDATA", 128'(mData), 128'(0));
    checkOutput("reset TKEEP", 128'(mKeep), 128'(0));
    checkOutput("reset TLAST", 128'(mLast), 128'(0));
    checkOutput("reset TREADY", 128'(sReady), 128'(1));
    @(posedge ACLK);
    #1;
    RST = 1'b0;

    // Two full words from a 4-beat packet
    pkt = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    applyStimulus(0);
    waitDrain();

    // Short packet with padding, then a fresh packet
    pkt = {32'h000000A0, 32'h000000A1, 32'h000000A2};
    applyStimulus(0);
    pkt = {32'h000000B0, 32'h000000B1};
    applyStimulus(0);
    // Single-beat packet at lane 0
    pkt = {32'h0000C0DE};
    applyStimulus(0);
    waitDrain();

    // Continuous 520-beat stream: must never stall
    pkt.delete();
    for (int i = 0; i < 520; i++) pkt.push_back(32'hFEDC0000 + 32'(i));
    stallCount = 0;
    startCycle = cycleCount;
    applyStimulus(0);
    checkOutput("stream stall count", 128'(stallCount), 128'(0));
    checkOutput("stream cycles", 128'(cycleCount - startCycle), 128'(520));
    waitDrain();

    // Backpressure: word pending for 10 cycles with next beat offered
    pkt = {$urandom(), $urandom(), $urandom(), $urandom()};
    modelPacket(2);
    mReady = 1'b0;
    driveBeat(pkt[0], 1'b0, 1'b0);
    driveBeat(pkt[1], 1'b0, 1'b1);
    sValid = 1'b1;
    sData  = pkt[2];
    sLast  = 1'b0;
    @(negedge ACLK);
    holdData = mData;
    holdKeep = mKeep;
    holdLast = mLast;
    repeat (10) begin
      @(negedge ACLK);
      checkOutput("stall TVALID held", 128'(mValid), 128'(1));
      checkOutput("stall TDATA stable", 128'(mData), 128'(holdData));
      checkOutput("stall TKEEP stable", 128'(mKeep), 128'(holdKeep));
      checkOutput("stall TLAST stable", 128'(mLast), 128'(holdLast));
      checkOutput("stall S_TREADY low", 128'(sReady), 128'(0));
    end
    @(posedge ACLK);
    #1;
    mReady = 1'b1;
    driveBeat(pkt[2], 1'b0, 1'b0);
    driveBeat(pkt[3], 1'b1, 1'b1);
    waitDrain();

    // Reset with a pending output word: it must be discarded
    mReady = 1'b0;
    driveBeat(32'hBAD00001, 1'b0, 1'b0);
    driveBeat(32'hBAD00002, 1'b0, 1'b1);
    RST = 1'b1;
    #1;
    checkOutput("reset drops pending TVALID", 128'(mValid), 128'(0));
    repeat (2) @(posedge ACLK);
    #1;
    RST    = 1'b0;
    mReady = 1'b1;
    repeat (5) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("no stale word after reset", 128'(mValid), 128'(0));
    @(posedge ACLK);
    #1;

    // Reset after one beat of a pair: next beat must land in lane 0
    driveBeat(32'hDEADBEEF, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    checkOutput("reset mid-pair TVALID", 128'(mValid), 128'(0));
    @(posedge ACLK);
    #1;
    RST = 1'b0;
    pkt = {32'h0E0E0E0E};
    applyStimulus(0);
    pkt = {32'h12345678, 32'h9ABCDEF0};
    applyStimulus(0);
    waitDrain();

    // Randomized packets under random backpressure
    randomReady = 1;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 9);
      pkt.delete();
      for (int k = 0; k < len; k++) pkt.push_back($urandom());
      applyStimulus(2);
    end
    randomReady = 0;
    @(posedge ACLK);
    #1;
    mReady = 1'b1;
    waitDrain();

    // RATIO=4 instance: 6-beat packet
    pkt = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    modelPacket(4);
    for (int k = 0; k < 6; k++) begin
      sValid4 = 1'b1;
      sData4  = pkt[k];
      sLast4  = (k == 5);
      @(negedge ACLK);
      checkOutput("dut4 S_TREADY", 128'(sReady4), 128'(1));
      @(posedge ACLK);
      #1;
    end
    sValid4 = 1'b0;
    sLast4  = 1'b0;
    waitDrain();

    repeat (5) @(posedge ACLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
